// File: rtl/mp_add_seq.sv
// Multi-precision add/subtract sequencer: feeds one limb per cycle into an external
// WIDTH-bit adder, chains its carry, and streams result limbs with final carry/overflow.
module mp_add_seq #(
    parameter int WIDTH     = 32,
    parameter int MAX_LIMBS = 8,
    parameter int CNT_W     = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] num_limbs,
    input  logic             sub,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_cin,
    input  logic [WIDTH-1:0] add_sum,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic [CNT_W-1:0] out_idx,
    output logic             out_last,
    output logic             done,
    output logic             carry_out,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] MAX_N = CNT_W'(MAX_LIMBS);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] n_r;
    logic [CNT_W-1:0] cnt;
    logic             sub_r;
    logic             carry_r;
    logic             start_ok;
    logic             accept;
    logic             last_limb;

    logic             vld_p1;
    logic [WIDTH-1:0] sum_p1;
    logic [CNT_W-1:0] idx_p1;
    logic             last_p1;

    // Two's-complement overflow: operands share a sign that the result does not.
    function automatic logic ovf_f(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb ~^ b_msb) & (s_msb ^ a_msb);
    endfunction

    assign add_a   = in_a;
    assign add_b   = sub_r ? ~in_b : in_b;
    assign add_cin = carry_r;

    assign start_ok  = start && (num_limbs != '0) && (num_limbs <= MAX_N);
    assign last_limb = (cnt == n_r - 1'b1);
    assign accept    = in_valid && in_ready;
    assign busy      = (state != IDLE);

    assign out_valid = vld_p1;
    assign out_sum   = sum_p1;
    assign out_idx   = idx_p1;
    assign out_last  = last_p1;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        case (state)
            IDLE: begin
                if (start_ok) state_nxt = RUN;
            end
            RUN: begin
                in_ready = !vld_p1 || out_ready;
                if (in_valid && in_ready && last_limb) state_nxt = FLUSH;
            end
            FLUSH: begin
                if (vld_p1 && out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_r       <= '0;
            cnt       <= '0;
            sub_r     <= 1'b0;
            carry_r   <= 1'b0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= (state == FLUSH) && vld_p1 && out_ready;
            if (state == IDLE && start_ok) begin
                n_r       <= num_limbs;
                sub_r     <= sub;
                carry_r   <= sub;
                cnt       <= '0;
                carry_out <= 1'b0;
                overflow  <= 1'b0;
            end
            if (accept) begin
                carry_r <= add_cout;
                cnt     <= cnt + 1'b1;
                if (last_limb) begin
                    carry_out <= add_cout;
                    overflow  <= ovf_f(in_a[WIDTH-1], add_b[WIDTH-1], add_sum[WIDTH-1]);
                end
            end
        end
    end

    // p1: registered adder result, single output slot with pass-through ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1  <= 1'b0;
            sum_p1  <= '0;
            idx_p1  <= '0;
            last_p1 <= 1'b0;
        end else if (accept) begin
            vld_p1  <= 1'b1;
            sum_p1  <= add_sum;
            idx_p1  <= cnt;
            last_p1 <= last_limb;
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq: wide-integer reference model, per-cycle output compare.
module tb_mp_add_seq;

    localparam int W  = 32;
    localparam int ML = 8;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [CW-1:0] num_limbs;
    logic          sub;
    logic          busy;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_a, in_b;
    logic [W-1:0]  add_a, add_b;
    logic          add_cin;
    logic [W-1:0]  add_sum;
    logic          add_cout;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_sum;
    logic [CW-1:0] out_idx;
    logic          out_last;
    logic          done;
    logic          carry_out;
    logic          overflow;

    mp_add_seq #(.WIDTH(W), .MAX_LIMBS(ML), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_limbs(num_limbs), .sub(sub),
        .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum),
        .add_cout(add_cout), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_idx(out_idx), .out_last(out_last), .done(done),
        .carry_out(carry_out), .overflow(overflow)
    );

    // The external carry-lookahead adder, modelled behaviourally.
    assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  sum;
        logic [CW-1:0] idx;
        logic          last;
    } beat_t;

    typedef struct {
        logic cout;
        logic ovf;
    } fin_t;

    beat_t        beat_q[$];
    fin_t         op_q[$];
    logic         done_pend;
    logic [W-1:0] got_sum[ML];
    logic         got_cout, got_ovf;
    int           errors = 0;
    int           checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Whole-operand reference: result = A + (sub ? ~B : B) + sub over n*W bits.
    task automatic push_model(input int n, input logic s, input logic [ML*W-1:0] a,
                              input logic [ML*W-1:0] b);
        logic [ML*W:0] mask, aw, bw, r;
        beat_t         bt;
        fin_t          f;
        int            top;
        top  = n * W;
        mask = ({{ML*W{1'b0}}, 1'b1} << top) - 1'b1;
        aw   = {1'b0, a} & mask;
        bw   = (s ? ~{1'b0, b} : {1'b0, b}) & mask;
        r    = aw + bw + {{ML*W{1'b0}}, s};
        for (int i = 0; i < n; i++) begin
            bt.sum  = r[i*W +: W];
            bt.idx  = CW'(i);
            bt.last = (i == n - 1);
            beat_q.push_back(bt);
        end
        f.cout = r[top];
        f.ovf  = (aw[top-1] == bw[top-1]) && (r[top-1] != aw[top-1]);
        op_q.push_back(f);
    endtask

    always @(negedge clk) begin
        beat_t bt;
        fin_t  f;
        if (!rst_n) begin
            beat_q.delete();
            op_q.delete();
            done_pend = 1'b0;
        end else begin
            chk("done", done, done_pend);
            if (done && op_q.size() > 0) begin
                f = op_q.pop_front();
                chk("carry_out", carry_out, f.cout);
                chk("overflow", overflow, f.ovf);
                got_cout = carry_out;
                got_ovf  = overflow;
            end
            done_pend = 1'b0;
            if (out_valid && out_ready) begin
                if (beat_q.size() == 0) begin
                    chk("unexpected_beat", 1'b1, 1'b0);
                end else begin
                    bt = beat_q.pop_front();
                    chk("out_sum", out_sum, bt.sum);
                    chk("out_idx", out_idx, bt.idx);
                    chk("out_last", out_last, bt.last);
                    got_sum[out_idx[2:0]] = out_sum;
                    done_pend = bt.last;
                end
            end
        end
    end

    task automatic feed_limb(input logic [W-1:0] a, input logic [W-1:0] b);
        logic acc;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        acc      = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("in_ready_timeout", 1'b0, 1'b1);
    endtask

    task automatic run_op(input int n, input logic s, input logic [ML*W-1:0] a,
                          input logic [ML*W-1:0] b, input bit stall, input bit poke);
        logic seen;
        for (int i = 0; i < ML; i++) got_sum[i] = 'x;
        got_cout = 1'bx;
        got_ovf  = 1'bx;
        push_model(n, s, a, b);
        @(posedge clk); #1;
        start = 1'b1; num_limbs = CW'(n); sub = s;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1'b1);
        for (int i = 0; i < n; i++) begin
            if (poke && i == 1) begin
                start = 1'b1; num_limbs = 4'd1; sub = !s;
            end
            feed_limb(a[i*W +: W], b[i*W +: W]);
            start = 1'b0;
            if (stall && i == 0) begin
                out_ready = 1'b0;
                in_a = a[W +: W];
                in_b = b[W +: W];
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    chk("stall_in_ready", in_ready, 1'b0);
                    chk("stall_out_idx", out_idx, 4'd0);
                    @(posedge clk); #1;
                end
                out_ready = 1'b1;
            end
        end
        in_valid = 1'b0;
        if (poke) begin
            chk("busy_in_flush", busy, 1'b1);
            start = 1'b1; num_limbs = 4'd2; sub = s;
            @(posedge clk); #1;
            start = 1'b0;
        end
        seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) chk("done_timeout", 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("busy_after_done", busy, 1'b0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_busy", busy, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_last", out_last, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_carry_out", carry_out, 1'b0);
        chk("rst_overflow", overflow, 1'b0);
        chk("rst_out_sum", out_sum, 32'h0);
        chk("rst_out_idx", out_idx, 4'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [ML*W-1:0] a, b;
        logic [128:0]    ref128;
        rst_n = 1'b0; start = 1'b0; num_limbs = '0; sub = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs();
        rst_n = 1'b1;

        // Two-limb add with carry ripple between limbs
        a = '0; b = '0;
        a[63:0] = 64'h00000001_FFFFFFFF;
        b[63:0] = 64'h00000000_00000001;
        run_op(2, 1'b0, a, b, 0, 0);
        chk("t1_limb0", got_sum[0], 32'h00000000);
        chk("t1_limb1", got_sum[1], 32'h00000002);
        chk("t1_cout", got_cout, 1'b0);
        chk("t1_ovf", got_ovf, 1'b0);

        a = '0; b = '0; a[31:0] = 32'hFFFFFFFF; b[31:0] = 32'h1;
        run_op(1, 1'b0, a, b, 0, 0);
        chk("t2_sum", got_sum[0], 32'h00000000);
        chk("t2_cout", got_cout, 1'b1);
        chk("t2_ovf", got_ovf, 1'b0);

        a = '0; b = '0; a[31:0] = 32'h7FFFFFFF; b[31:0] = 32'h1;
        run_op(1, 1'b0, a, b, 0, 0);
        chk("t3_sum", got_sum[0], 32'h80000000);
        chk("t3_cout", got_cout, 1'b0);
        chk("t3_ovf", got_ovf, 1'b1);

        a = '0; b = '0; a[31:0] = 32'd5; b[31:0] = 32'd7;
        run_op(1, 1'b1, a, b, 0, 0);
        chk("t4_sum", got_sum[0], 32'hFFFFFFFE);
        chk("t4_cout", got_cout, 1'b0);

        a = '0; b = '0; a[31:0] = 32'h80000000; b[31:0] = 32'h1;
        run_op(1, 1'b1, a, b, 0, 0);
        chk("t5_sum", got_sum[0], 32'h7FFFFFFF);
        chk("t5_cout", got_cout, 1'b1);
        chk("t5_ovf", got_ovf, 1'b1);

        // Four limbs with output stalled after the first beat
        a = '0; b = '0;
        a[127:0] = {$urandom, $urandom, $urandom, $urandom};
        b[127:0] = {$urandom, $urandom, $urandom, $urandom};
        run_op(4, 1'b0, a, b, 1, 0);
        ref128 = {1'b0, a[127:0]} + {1'b0, b[127:0]};
        chk("t6_lo", {got_sum[1], got_sum[0]}, ref128[63:0]);
        chk("t6_hi", {got_sum[3], got_sum[2]}, ref128[127:64]);
        chk("t6_cout", got_cout, ref128[128]);

        // Stray start pulses in RUN and FLUSH must not disturb a 3-limb subtract
        a = '0; b = '0;
        a[95:0] = 96'h00000001_00000000_00000000;
        b[95:0] = 96'h00000000_00000000_00000001;
        run_op(3, 1'b1, a, b, 0, 1);
        chk("t7_limb0", got_sum[0], 32'hFFFFFFFF);
        chk("t7_limb1", got_sum[1], 32'hFFFFFFFF);
        chk("t7_limb2", got_sum[2], 32'h00000000);
        chk("t7_cout", got_cout, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("t7_idle_busy", busy, 1'b0);

        // Illegal limb counts are ignored in IDLE
        start = 1'b1; num_limbs = 4'd0;
        @(posedge clk); #1;
        num_limbs = 4'd9;
        @(posedge clk); #1;
        start = 1'b0;
        chk("t8_busy_n0_n9", busy, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("t8_busy_later", busy, 1'b0);

        // Reset mid-operation after two of four limbs
        a = '0; b = '0;
        a[127:0] = {32'h4, 32'h3, 32'h2, 32'h1};
        b[127:0] = {32'h40, 32'h30, 32'h20, 32'h10};
        push_model(4, 1'b0, a, b);
        start = 1'b1; num_limbs = 4'd4; sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        feed_limb(a[31:0], b[31:0]);
        feed_limb(a[63:32], b[63:32]);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        a = '0; b = '0; a[31:0] = 32'd3; b[31:0] = 32'd1;
        run_op(1, 1'b1, a, b, 0, 0);
        chk("t9_sum", got_sum[0], 32'h00000002);
        chk("t9_cout", got_cout, 1'b1);

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
